// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder BIST controller: FSM states,
// error counter width and maximal-length LFSR feedback polynomials.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    localparam int unsigned LFSR_MAX_W = 33;

    function automatic logic [LFSR_MAX_W-1:0] bit_at(int unsigned n);
        return LFSR_MAX_W'(1) << n;
    endfunction

    // Primitive polynomial coefficients below x^w (bit e = coefficient of x^e), odd w 3..33.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_poly(int unsigned w);
        logic [LFSR_MAX_W-1:0] p;
        p = bit_at(0);
        case (w)
            3:       p = p | bit_at(2);
            5:       p = p | bit_at(3);
            7:       p = p | bit_at(6);
            9:       p = p | bit_at(5);
            11:      p = p | bit_at(9);
            13:      p = p | bit_at(4) | bit_at(3) | bit_at(1);
            15:      p = p | bit_at(14);
            17:      p = p | bit_at(14);
            19:      p = p | bit_at(6) | bit_at(2) | bit_at(1);
            21:      p = p | bit_at(19);
            23:      p = p | bit_at(18);
            25:      p = p | bit_at(22);
            27:      p = p | bit_at(5) | bit_at(2) | bit_at(1);
            29:      p = p | bit_at(27);
            31:      p = p | bit_at(28);
            33:      p = p | bit_at(20);
            default: p = '0;
        endcase
        return p;
    endfunction

    // Feedback mask for a shift-left Fibonacci register: bit i carries the x^(w-1-i) term.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_fib_mask(int unsigned w);
        logic [LFSR_MAX_W-1:0] poly;
        logic [LFSR_MAX_W-1:0] m;
        poly = lfsr_poly(w);
        m    = '0;
        for (int unsigned i = 0; i < w; i++) begin
            if (((poly >> (w - 1 - i)) & LFSR_MAX_W'(1)) != '0) begin
                m = m | bit_at(i);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Fibonacci LFSR pattern source with synchronous reload and single-step advance.
module bist_lfsr #(
    parameter int unsigned W    = 9,
    parameter logic [W-1:0] TAPS = '0,
    parameter logic [W-1:0] SEED = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    output logic [W-1:0] lfsr
);

    logic fb_c;

    assign fb_c = ^(lfsr & TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else if (load) begin
            lfsr <= SEED;
        end else if (step) begin
            lfsr <= {lfsr[W-2:0], fb_c};
        end
    end

endmodule

// File: rtl/adder_bist_ctrl.sv
// BIST controller for a WIDTH-bit adder: drives LFSR vectors, checks {cout,sum}.
// Optional first-failing-vector capture with ADDER_BIST_FIRST_FAIL_EN.
module adder_bist_ctrl
    import adder_bist_pkg::*;
#(
    parameter int unsigned      WIDTH       = 4,
    parameter int unsigned      NUM_VECTORS = 16,
    parameter logic [2*WIDTH:0] SEED        = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             cin,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic             fail_cin
);

    localparam int unsigned LFSR_W = 2 * WIDTH + 1;
    localparam int unsigned CNT_W  = 10;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(lfsr_fib_mask(LFSR_W));
    localparam logic [CNT_W-1:0]  LAST_VEC  = CNT_W'(NUM_VECTORS - 1);

    state_t              state;
    state_t              state_nxt;
    logic                load_c;
    logic                step_c;
    logic                drive_c;
    logic                check_c;
    logic                last_c;
    logic                mismatch_c;
    logic [WIDTH:0]      golden_c;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [CNT_W-1:0]    vec_cnt;

    bist_lfsr #(
        .W    (LFSR_W),
        .TAPS (LFSR_TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_c),
        .step  (step_c),
        .lfsr  (lfsr_q)
    );

    assign last_c     = (vec_cnt == LAST_VEC);
    assign golden_c   = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);
    assign mismatch_c = ({cout, sum} != golden_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // start only matters while parked; a run cannot be restarted mid-flight
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = DRIVE;
            DRIVE:      state_nxt = CHECK;
            CHECK:      state_nxt = last_c ? DONE : DRIVE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_c  = 1'b0;
        step_c  = 1'b0;
        drive_c = 1'b0;
        check_c = 1'b0;
        case (state)
            IDLE, DONE: load_c = start;
            DRIVE:      drive_c = 1'b1;
            CHECK: begin
                check_c = 1'b1;
                step_c  = 1'b1;
            end
            default: ;
        endcase
    end

    // busy covers the start edge through the last check so busy/done hand over cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a         <= '0;
            b         <= '0;
            cin       <= 1'b0;
            vec_cnt   <= '0;
            err_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            if (drive_c) begin
                {a, b, cin} <= lfsr_q;
            end
            if (load_c) begin
                vec_cnt   <= '0;
                err_count <= '0;
            end else if (check_c) begin
                vec_cnt <= vec_cnt + CNT_W'(1);
                if (mismatch_c && (err_count != ERR_MAX)) begin
                    err_count <= err_count + ERR_W'(1);
                end
            end
            busy <= load_c || (state == DRIVE) || (state == CHECK);
            done <= (state == DONE) && !load_c;
            pass <= (state == DONE) && !load_c && (err_count == '0);
        end
    end

`ifdef ADDER_BIST_FIRST_FAIL_EN
    // err_count is cleared on start, so zero here marks the first mismatch of the run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_a   <= '0;
            fail_b   <= '0;
            fail_cin <= 1'b0;
        end else if (load_c) begin
            fail_a   <= '0;
            fail_b   <= '0;
            fail_cin <= 1'b0;
        end else if (check_c && mismatch_c && (err_count == '0)) begin
            fail_a   <= a;
            fail_b   <= b;
            fail_cin <= cin;
        end
    end
`else
    assign fail_a   = '0;
    assign fail_b   = '0;
    assign fail_cin = 1'b0;
`endif

endmodule
